// File: rtl/cpu_io_host.sv
// rtl/cpu_io_host.sv - host bridge: queued words held on the CPU input port, CPU output changes captured
module cpu_io_host #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 90
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] input_pin,
    output logic        input_enable,
    input  logic [15:0] output_pin,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
    state_t state, state_nxt;

    logic [15:0]   in_mem [DEPTH];
    logic [AW-1:0] in_wr, in_rd;
    logic [CW-1:0] in_cnt;
    logic [HW-1:0] hold_cnt;
    logic          in_push, in_pop, load;

    logic [15:0]   out_mem [DEPTH];
    logic [AW-1:0] out_wr, out_rd;
    logic [CW-1:0] out_cnt;
    logic [15:0]   prev_out;
    logic          cap, out_push, out_pop;

    // in_ready depends on the count only, so a slot freed by this edge's pop is not reusable until next cycle
    assign in_ready = (in_cnt != FULL);
    assign in_push  = in_valid && in_ready;

    always_comb begin
        state_nxt    = state;
        load         = 1'b0;
        in_pop       = 1'b0;
        input_enable = 1'b0;
        case (state)
            IDLE: begin
                if (in_cnt != '0) begin
                    load      = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                input_enable = 1'b1;
                if (hold_cnt == '0) begin
                    in_pop    = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_wr     <= '0;
            in_rd     <= '0;
            in_cnt    <= '0;
            hold_cnt  <= '0;
            input_pin <= 16'h0000;
            for (int i = 0; i < DEPTH; i++) in_mem[i] <= 16'h0000;
        end else begin
            if (in_push) begin
                in_mem[in_wr] <= in_data;
                in_wr         <= in_wr + 1'b1;
            end
            if (in_pop) in_rd <= in_rd + 1'b1;
            in_cnt <= in_cnt + CW'(in_push) - CW'(in_pop);
            if (load) begin
                input_pin <= in_mem[in_rd];
                hold_cnt  <= HOLD_LOAD;
            end else if (state == DRIVE && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

    // A change on a full FIFO still lands if the host pops on the same edge
    assign cap       = (output_pin != prev_out);
    assign out_pop   = out_valid && out_ready;
    assign out_push  = cap && ((out_cnt != FULL) || out_pop);
    assign out_valid = (out_cnt != '0);
    assign out_data  = out_mem[out_rd];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_wr   <= '0;
            out_rd   <= '0;
            out_cnt  <= '0;
            prev_out <= 16'h0000;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) out_mem[i] <= 16'h0000;
        end else begin
            if (cap) prev_out <= output_pin;
            if (out_push) begin
                out_mem[out_wr] <= output_pin;
                out_wr          <= out_wr + 1'b1;
            end
            if (out_pop) out_rd <= out_rd + 1'b1;
            out_cnt <= out_cnt + CW'(out_push) - CW'(out_pop);
            if (cap && !out_push) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cpu_io_host.sv
// tb/tb_cpu_io_host.sv - directed scoreboard bench for cpu_io_host (default hold and single-cycle hold)
module tb_cpu_io_host;
    localparam int H = 90;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_data, input_pin, output_pin, out_data;
    logic        in_valid, in_ready, input_enable, out_valid, out_ready, overflow;

    logic [15:0] h_in_data, h_input_pin, h_output_pin, h_out_data;
    logic        h_in_valid, h_in_ready, h_input_enable, h_out_valid, h_out_ready, h_overflow;

    always #5 clk = ~clk;

    cpu_io_host #(.DEPTH(D), .HOLD_CYCLES(H)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .input_pin(input_pin), .input_enable(input_enable),
        .output_pin(output_pin), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .overflow(overflow)
    );

    cpu_io_host #(.DEPTH(D), .HOLD_CYCLES(1)) dut_h1 (
        .clk(clk), .reset(reset),
        .in_data(h_in_data), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .input_pin(h_input_pin), .input_enable(h_input_enable),
        .output_pin(h_output_pin), .out_data(h_out_data), .out_valid(h_out_valid),
        .out_ready(h_out_ready), .overflow(h_overflow)
    );

    int          vectors = 0;
    int          errors  = 0;
    logic [15:0] in_q[$];
    logic [15:0] out_q[$];
    logic [15:0] h_q[$];
    logic [15:0] tb_prev;
    logic [15:0] hw[3] = '{16'hA001, 16'hA002, 16'hA003};
    logic [8:0]  pat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_in(input logic [15:0] w);
        bit done;
        done     = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int k = 0; k < 600 && !done; k++) begin
            done = in_ready;
            if (done) in_q.push_back(w);
            step();
        end
        in_valid = 1'b0;
        check("push_accept", 32'(done), 1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 1500; k++) begin
            if (in_q.size() == 0 && !input_enable) break;
            step();
        end
        check("delivery_drain", 32'(in_q.size() == 0 && !input_enable), 1);
    endtask

    task automatic out_cycle(input logic [15:0] v, input logic rdy);
        output_pin = v;
        out_ready  = rdy;
        if (rdy && out_q.size() > 0) begin
            check("out_valid_at_pop", 32'(out_valid), 1);
            check("out_data", 32'(out_data), 32'(out_q.pop_front()));
        end
        if (v != tb_prev) begin
            if (out_q.size() < D) out_q.push_back(v);
            tb_prev = v;
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic drain_out();
        while (out_q.size() > 0) out_cycle(tb_prev, 1'b1);
        check("out_empty_after_drain", 32'(out_valid), 0);
    endtask

    // Delivery monitor: every rising input_enable must carry the next queued word
    int          mcyc = 0, last_rise = -1, high_len = 0;
    bit          prev_en = 1'b0, stable = 1'b1;
    logic [15:0] held = 16'h0000;

    always @(negedge clk) begin
        mcyc++;
        if (!reset) begin
            prev_en   = 1'b0;
            last_rise = -1;
            high_len  = 0;
        end else begin
            if (input_enable && !prev_en) begin
                if (last_rise >= 0) check("word_spacing", 32'((mcyc - last_rise) >= H + 2), 1);
                last_rise = mcyc;
                check("delivery_pending", 32'(in_q.size() > 0), 1);
                if (in_q.size() > 0) check("deliver_word", 32'(input_pin), 32'(in_q.pop_front()));
                held     = input_pin;
                stable   = 1'b1;
                high_len = 1;
            end else if (input_enable) begin
                high_len++;
                if (input_pin !== held) stable = 1'b0;
            end else if (prev_en) begin
                check("hold_len", high_len, H);
                check("pin_stable", 32'(stable), 1);
                check("pin_retained", 32'(input_pin), 32'(held));
            end
            prev_en = input_enable;
        end
    end

    initial begin
        int highs;
        reset = 1'b0; in_valid = 1'b0; in_data = 16'h0; output_pin = 16'h0; out_ready = 1'b0;
        h_in_valid = 1'b0; h_in_data = 16'h0; h_output_pin = 16'h0; h_out_ready = 1'b0;
        tb_prev = 16'h0000;
        #12;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_input_enable", 32'(input_enable), 0);
        check("rst_input_pin", 32'(input_pin), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_h1_enable", 32'(h_input_enable), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        step();

        push_in(16'hF0F0);
        check("en_at_push_edge", 32'(input_enable), 0);
        step();
        check("en_one_edge_later", 32'(input_enable), 1);
        check("pin_f0f0", 32'(input_pin), 32'hF0F0);
        wait_idle();
        check("pin_kept_idle", 32'(input_pin), 32'hF0F0);

        push_in(16'h0001);
        push_in(16'h0002);
        push_in(16'h0003);
        push_in(16'h0004);
        check("in_ready_full", 32'(in_ready), 0);
        push_in(16'h0005);
        wait_idle();

        out_cycle(16'h0000, 1'b0);
        out_cycle(16'h0000, 1'b0);
        check("no_capture_on_zero", 32'(out_valid), 0);
        out_cycle(16'h1234, 1'b0);
        check("out_valid_first_change", 32'(out_valid), 1);
        out_cycle(16'h1234, 1'b0);
        out_cycle(16'hABCD, 1'b0);
        drain_out();

        out_cycle(16'h1111, 1'b0);
        out_cycle(16'h2222, 1'b0);
        out_cycle(16'h3333, 1'b0);
        out_cycle(16'h4444, 1'b0);
        check("no_overflow_at_four", 32'(overflow), 0);
        out_cycle(16'h5555, 1'b0);
        check("overflow_at_fifth", 32'(overflow), 1);
        out_cycle(16'h6666, 1'b1);
        check("overflow_kept", 32'(overflow), 1);
        drain_out();

        push_in(16'h5A5A);
        push_in(16'h7777);
        repeat (39) step();
        check("drive_before_reset", 32'(input_enable), 1);
        reset = 1'b0;
        #1;
        in_q.delete();
        out_q.delete();
        tb_prev = 16'h0000;
        check("abort_enable", 32'(input_enable), 0);
        check("abort_pin", 32'(input_pin), 0);
        check("abort_in_ready", 32'(in_ready), 1);
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_overflow", 32'(overflow), 0);
        check("abort_out_data", 32'(out_data), 0);
        step();
        step();
        reset = 1'b1;
        highs = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (input_enable) highs++;
        end
        check("no_redelivery", highs, 0);

        pat = '0;
        for (int i = 0; i < 9; i++) begin
            if (i < 3) begin
                h_in_data  = hw[i];
                h_in_valid = 1'b1;
                check("h1_in_ready", 32'(h_in_ready), 1);
                h_q.push_back(hw[i]);
            end else begin
                h_in_valid = 1'b0;
            end
            step();
            pat = {pat[7:0], h_input_enable};
            if (h_input_enable && h_q.size() > 0) check("h1_word", 32'(h_input_pin), 32'(h_q.pop_front()));
        end
        check("h1_enable_pattern", 32'(pat), 32'b010010010);
        check("h1_all_delivered", h_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/cpu_io_host.md
CPU_IO_HOST -- requirements
Module: cpu_io_host

Interface
REQ-001 Parameter DEPTH, default 4, entries in each FIFO (power of two, >=2).
REQ-002 Parameter HOLD_CYCLES, default 90, clk cycles input_enable stays high per word (>=1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-005 in_data  input  16  host word to deliver to CPU.
REQ-006 in_valid  input  1  host offers in_data.
REQ-007 in_ready  output  1  input FIFO not full; word accepted on a clk edge with in_valid && in_ready.
REQ-008 input_pin  output  16  word presented to CPU input port.
REQ-009 input_enable  output  1  high while input_pin carries a valid word.
REQ-010 output_pin  input  16  CPU output port, sampled every clk.
REQ-011 out_data  output  16  oldest captured CPU output word.
REQ-012 out_valid  output  1  output FIFO not empty.
REQ-013 out_ready  input  1  host takes out_data on a clk edge with out_valid && out_ready.
REQ-014 overflow  output  1  sticky; a captured word was dropped.

Function
REQ-015 Input FIFO: DEPTH x 16, first-in first-out; push on in_valid && in_ready; pop only by delivery FSM.
REQ-016 Delivery FSM states IDLE, DRIVE, GAP; reset state IDLE.
REQ-017 IDLE: input_enable=0; if input FIFO non-empty, next edge loads input_pin with head word, input_enable=1, hold counter=HOLD_CYCLES-1, go DRIVE.
REQ-018 DRIVE: input_enable=1, input_pin stable; counter decrements each edge; at edge where counter==0, pop head, input_enable=0, go GAP.
REQ-019 GAP: exactly one cycle with input_enable=0; then IDLE.
REQ-020 input_enable high for exactly HOLD_CYCLES consecutive cycles per word; minimum spacing between words HOLD_CYCLES+2 cycles.
REQ-021 input_pin retains last delivered word outside DRIVE; it changes only on IDLE->DRIVE.
REQ-022 Push into input FIFO on same edge as pop when full: pop frees slot, but in_ready reflects full and push is not accepted that cycle (in_ready combinational on count only).
REQ-023 Capture: register prev_out; each edge where output_pin != prev_out, push output_pin into output FIFO and set prev_out=output_pin.
REQ-024 Output FIFO: DEPTH x 16; out_data = head; pop on out_valid && out_ready.
REQ-025 Capture push when output FIFO full and no pop that edge: word dropped, overflow set to 1, prev_out still updated.
REQ-026 Capture push when full with pop on same edge: both succeed, count unchanged, overflow unchanged.
REQ-027 overflow clears only on reset.
REQ-028 Pointers wrap modulo DEPTH; counts range 0..DEPTH.

Reset
REQ-029 reset low asynchronously forces: FSM IDLE, both FIFOs empty, counter 0, input_pin=16'h0000, input_enable=0, prev_out=16'h0000, out_valid=0, out_data=16'h0000, overflow=0, in_ready=1.
REQ-030 reset asserted mid-DRIVE aborts delivery; the word in flight is discarded, not redelivered.
REQ-031 First rising edge after reset deassertion operates normally; no synchronizer stages required.

Verification
REQ-032 Push 16'hF0F0 after reset, HOLD_CYCLES=90 -> input_pin=16'hF0F0, input_enable high exactly 90 cycles starting one edge after push, then low.
REQ-033 Push 16'h0001,0002,0003,0004 back-to-back, then a fifth -> in_ready=0 after fourth; words delivered in order, each separated by >=92 cycles.
REQ-034 output_pin sequence 0000,0000,1234,1234,ABCD -> output FIFO holds exactly 1234, ABCD; out_valid high after first change.
REQ-035 out_ready=0, five distinct output_pin values -> four stored, overflow=1, fifth dropped; then single pop with simultaneous new value -> count stays 4.
REQ-036 reset low at cycle 40 of DRIVE -> input_enable=0 and input_pin=0000 immediately, FIFOs empty, overflow=0.
REQ-037 HOLD_CYCLES=1: input_enable high one cycle per word; three queued words delivered at 3-cycle period.
